ads_scan_ctrl: RTL and testbench
================================

Name: ads_scan_ctrl

Overview:
Parametrised multi-channel successor to the single-channel ADS controller. It sequences single-shot conversions on an ADS1115-class I2C ADC across up to 4 single-ended inputs, selected by a channel mask. It drives the existing I2C master (iic_cfg) through its write/read request handshake and waits the conversion time. Results are emitted as a tagged stream of channel index plus 16-bit code.

Parameters:
CH_NUM, 4, number of scanned inputs (1..4)
PGA, 3'b001, config PGA field [11:9]
DR, 3'b100, config data-rate field [7:5]
CONV_CYCLES, 80000, clk cycles waited after config write before the result read
GAP_CYCLES, 1000, idle clk cycles between scan rounds
AVG_SHIFT, 2, log2 of the sample count averaged per channel (used only with ADS_AVG_EN)

Ports:
clk  in  1  system clock (10 MHz nominal)
rst_n  in  1  asynchronous active-low reset
scan_en  in  1  level; 1 = run continuous scan rounds
ch_mask  in  CH_NUM  per-channel enable; bit i = AINi
m_wr_req  out  1  write request to I2C master
m_rd_req  out  1  read request to I2C master
m_reg_addr  out  2  ADS pointer register (1 = config, 0 = conversion)
m_wdata  out  16  config word
m_rdata  in  16  read data from master, valid with m_done
m_done  in  1  one-cycle pulse: transaction finished
m_ack_err  in  1  valid with m_done; 1 = NACK
ad_voltage  out  16  result code
ad_ch  out  2  channel of ad_voltage
ad_voltage_valid  out  1  one-cycle strobe
err  out  1  one-cycle strobe on NACK
busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; channel pointer = 0; counters = 0.
- States: IDLE, SEL, CFG, CFG_W, CONV, RD, RD_W, EMIT, GAP.
- IDLE: when scan_en = 1 and ch_mask != 0, go to SEL.
- SEL: pointer advances to the next set mask bit, starting at the current pointer and wrapping modulo CH_NUM. This takes 1 cycle.
- Config word: {1'b1, 1'b1, ch[1:0], PGA, 1'b1, DR, 5'b00011}. Single-shot mode, comparator disabled.
- CFG: assert m_wr_req with m_reg_addr = 1 and m_wdata = config word, then go to CFG_W.
- Request handshake (both write and read):
  - Request is held high until m_done.
  - Request drops in the cycle after m_done.
  - m_reg_addr and m_wdata stay stable while the request is high.
  - m_wr_req and m_rd_req are never high together.
- On m_done in CFG_W or RD_W:
  - If m_ack_err = 1: pulse err, skip this channel, go to the next mask bit (SEL), or to GAP if the round is finished.
  - Otherwise continue: CFG_W goes to CONV; RD_W goes to EMIT.
- CONV: counts CONV_CYCLES clocks (counter of width $clog2(CONV_CYCLES+1)), then goes to RD.
- RD: assert m_rd_req with m_reg_addr = 0; m_rdata is captured on m_done.
- EMIT: ad_voltage, ad_ch and ad_voltage_valid are updated on the same edge. The valid strobe lasts exactly 1 cycle. ad_voltage and ad_ch hold until the next emit.
- Round end: after the highest enabled channel, go to GAP for GAP_CYCLES, then back to SEL. If scan_en = 0 at round end, go to IDLE instead.
- scan_en deasserted mid-round: the current channel completes, then the FSM goes to IDLE. An I2C transaction is never aborted.
- ch_mask is sampled in SEL only. If the mask becomes 0, go to IDLE.
- Single-bit mask: the same channel repeats every round.
- m_done outside CFG_W/RD_W is ignored.
- rst_n asserted mid-transaction: immediate return to reset values; requests drop asynchronously.

Optional Feature:
ADS_AVG_EN
- Defined:
  - Each channel is converted 2^AVG_SHIFT times back-to-back (CFG→RD loop).
  - Results are summed in a (16+AVG_SHIFT)-bit signed accumulator.
  - ad_voltage = accumulator >>> AVG_SHIFT (arithmetic shift), emitted once per channel.
  - A NACK discards the partial sum and skips the channel.
- Undefined: one conversion per channel; no accumulator logic is synthesised.

Decomposition:
- Package ads_pkg holds:
  - FSM state enum
  - register pointer constants (REG_CONV = 0, REG_CFG = 1)
  - config field constants (OS, MODE_SS, COMP_DIS = 5'b00011)
  - function building the config word from (ch, PGA, DR)
- One sub-module, ads_ch_arb: round-robin next-set-bit finder over ch_mask with wrap and last-channel flag. It is purely combinational, about 40 lines.

Test Plan:
- Reset: hold rst_n = 0 for 1000 ns → all outputs 0, busy = 0. Releasing with scan_en = 0 → no request.
- Single channel: ch_mask = 4'b0001, master model returns 16'h1234 → m_wdata = 16'hC383 with m_reg_addr = 1; then CONV_CYCLES later m_rd_req with m_reg_addr = 0; then ad_voltage = 16'h1234, ad_ch = 0, valid high 1 cycle.
- Mask skip/wrap: ch_mask = 4'b0101 → config words 16'hC383 then 16'hE383, ad_ch sequence 0, 2, 0, 2 with a GAP_CYCLES idle gap between rounds.
- NACK: m_ack_err = 1 on the ch2 config write → err pulses once, no ch2 emit, ch0 continues next round.
- scan_en dropped during ch0 CONV → ch0 result emitted, then IDLE, busy = 0, no further requests.
- ADS_AVG_EN with AVG_SHIFT = 2 and reads 16'h0010, 16'h0020, 16'h0030, 16'h0040 → single emit of 16'h0028. Reads of 16'hFFFC ×4 → 16'hFFFC.

Source files
------------

// File: rtl/ads_pkg.sv
// Shared types and constants for the ADS1115-class scan controller:
// FSM states, pointer-register addresses and the config-word builder.
package ads_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_SEL, S_CFG, S_CFG_W, S_CONV, S_RD, S_RD_W, S_EMIT, S_GAP
  } state_t;

  localparam logic [1:0] REG_CONV = 2'd0;
  localparam logic [1:0] REG_CFG  = 2'd1;

  localparam logic       OS       = 1'b1;
  localparam logic       MUX_SE   = 1'b1;  // MUX[2]=1 selects AINx versus GND
  localparam logic       MODE_SS  = 1'b1;
  localparam logic [4:0] COMP_DIS = 5'b00011;

  function automatic logic [15:0] cfg_word(input logic [1:0] ch,
                                           input logic [2:0] pga,
                                           input logic [2:0] dr);
    return {OS, MUX_SE, ch, pga, MODE_SS, dr, COMP_DIS};
  endfunction

endpackage

// File: rtl/ads_ch_arb.sv
// Round-robin next-set-bit finder over the channel mask, searching upward
// from the current pointer with wrap; flags when the pick is the top channel.
module ads_ch_arb #(
  parameter int CH_NUM = 4
) (
  input  logic [CH_NUM-1:0] ch_mask,
  input  logic [1:0]        start,
  output logic              found,
  output logic [1:0]        next_ch,
  output logic              last
);

  logic       hi_found;
  logic [1:0] hi_ch;
  logic [1:0] lo_ch;
  logic [1:0] top_ch;

  // Descending scan leaves the lowest qualifying index in hi_ch / lo_ch.
  always_comb begin
    hi_found = 1'b0;
    hi_ch    = 2'd0;
    lo_ch    = 2'd0;
    top_ch   = 2'd0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        lo_ch = 2'(i);
        if (i >= int'(start)) begin
          hi_found = 1'b1;
          hi_ch    = 2'(i);
        end
      end
    end
    for (int i = 0; i < CH_NUM; i++) begin
      if (ch_mask[i]) top_ch = 2'(i);
    end
  end

  assign found   = |ch_mask;
  assign next_ch = hi_found ? hi_ch : lo_ch;
  assign last    = found && (next_ch == top_ch);

endmodule

// File: rtl/ads_scan_ctrl.sv
// Multi-channel single-shot scan controller for an ADS1115-class ADC behind
// the iic_cfg master. Define ADS_AVG_EN to average 2^AVG_SHIFT samples/channel.
module ads_scan_ctrl
  import ads_pkg::*;
#(
  parameter int         CH_NUM      = 4,
  parameter logic [2:0] PGA         = 3'b001,
  parameter logic [2:0] DR          = 3'b100,
  parameter int         CONV_CYCLES = 80000,
  parameter int         GAP_CYCLES  = 1000,
  parameter int         AVG_SHIFT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_en,
  input  logic [CH_NUM-1:0] ch_mask,
  output logic              m_wr_req,
  output logic              m_rd_req,
  output logic [1:0]        m_reg_addr,
  output logic [15:0]       m_wdata,
  input  logic [15:0]       m_rdata,
  input  logic              m_done,
  input  logic              m_ack_err,
  output logic [15:0]       ad_voltage,
  output logic [1:0]        ad_ch,
  output logic              ad_voltage_valid,
  output logic              err,
  output logic              busy
);

  localparam int         CNT_MAX = (CONV_CYCLES > GAP_CYCLES) ? CONV_CYCLES : GAP_CYCLES;
  localparam int         CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [1:0] LAST_CH = 2'(CH_NUM - 1);

  if (CH_NUM < 1 || CH_NUM > 4 || AVG_SHIFT < 0 || AVG_SHIFT > 14) begin : g_param_chk
    $error("ads_scan_ctrl: parameter out of range");
  end

  state_t           state, nxt, end_st;
  logic [1:0]       ptr;
  logic             last_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_hit, in_wait, rsp_nack, rsp_ok, chan_done, more_smp;
  logic             arb_found, arb_last;
  logic [1:0]       arb_ch;

  ads_ch_arb #(.CH_NUM(CH_NUM)) u_arb (
    .ch_mask (ch_mask),
    .start   (ptr),
    .found   (arb_found),
    .next_ch (arb_ch),
    .last    (arb_last)
  );

`ifdef ADS_AVG_EN
  localparam int               ACC_W    = 16 + AVG_SHIFT;
  localparam logic [AVG_SHIFT:0] SMP_LAST = (AVG_SHIFT + 1)'((1 << AVG_SHIFT) - 1);

  logic signed [ACC_W-1:0] acc;
  logic [AVG_SHIFT:0]      n_smp;

  function automatic logic [15:0] avg_out(input logic signed [ACC_W-1:0] a);
    return 16'(a >>> AVG_SHIFT);
  endfunction

  assign more_smp = (n_smp != SMP_LAST);
`else
  logic [15:0] rd_q;

  assign more_smp = 1'b0;
`endif

  assign in_wait   = (state == S_CFG_W) || (state == S_RD_W);
  assign rsp_nack  = in_wait && m_done && m_ack_err;
  assign rsp_ok    = in_wait && m_done && !m_ack_err;
  assign chan_done = rsp_nack || (state == S_EMIT);
  assign cnt_hit   = (state == S_CONV) ? (cnt == CNT_W'(CONV_CYCLES - 1))
                                       : (cnt == CNT_W'(GAP_CYCLES - 1));
  // Where a finished (or skipped) channel leads: stop, end the round, or next bit.
  assign end_st    = !scan_en ? S_IDLE : (last_q ? S_GAP : S_SEL);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (scan_en && (|ch_mask)) nxt = S_SEL;
      S_SEL:   nxt = (scan_en && arb_found) ? S_CFG : S_IDLE;
      S_CFG:   nxt = S_CFG_W;
      S_CFG_W: if (m_done) nxt = m_ack_err ? end_st : S_CONV;
      S_CONV:  if (cnt_hit) nxt = S_RD;
      S_RD:    nxt = S_RD_W;
      S_RD_W:  if (m_done) nxt = m_ack_err ? end_st : (more_smp ? S_CFG : S_EMIT);
      S_EMIT:  nxt = end_st;
      S_GAP:   if (cnt_hit) nxt = scan_en ? S_SEL : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr              <= 2'd0;
      last_q           <= 1'b0;
      cnt              <= '0;
      m_wr_req         <= 1'b0;
      m_rd_req         <= 1'b0;
      m_reg_addr       <= 2'd0;
      m_wdata          <= 16'd0;
      ad_voltage       <= 16'd0;
      ad_ch            <= 2'd0;
      ad_voltage_valid <= 1'b0;
      err              <= 1'b0;
`ifdef ADS_AVG_EN
      acc              <= '0;
      n_smp            <= '0;
`else
      rd_q             <= 16'd0;
`endif
    end else begin
      err              <= rsp_nack;
      ad_voltage_valid <= (state == S_EMIT);

      if (state == S_CONV || state == S_GAP) cnt <= cnt_hit ? '0 : cnt + 1'b1;
      else                                   cnt <= '0;

      if (state == S_SEL) begin
        ptr    <= arb_ch;
        last_q <= arb_last;
      end else if (chan_done) begin
        ptr <= (ptr == LAST_CH) ? 2'd0 : ptr + 2'd1;
      end

      // Requests are held until m_done and released on the following edge.
      if (state == S_CFG) begin
        m_wr_req   <= 1'b1;
        m_reg_addr <= REG_CFG;
        m_wdata    <= cfg_word(ptr, PGA, DR);
      end else if (state == S_CFG_W && m_done) begin
        m_wr_req <= 1'b0;
      end

      if (state == S_RD) begin
        m_rd_req   <= 1'b1;
        m_reg_addr <= REG_CONV;
      end else if (state == S_RD_W && m_done) begin
        m_rd_req <= 1'b0;
      end

      if (state == S_EMIT) ad_ch <= ptr;
`ifdef ADS_AVG_EN
      if (state == S_SEL) begin
        acc   <= '0;
        n_smp <= '0;
      end else if (state == S_RD_W && rsp_ok) begin
        acc   <= acc + ACC_W'($signed(m_rdata));
        n_smp <= n_smp + 1'b1;
      end
      if (state == S_EMIT) ad_voltage <= avg_out(acc);
`else
      if (state == S_RD_W && rsp_ok) rd_q <= m_rdata;
      if (state == S_EMIT) ad_voltage <= rd_q;
`endif
    end
  end

endmodule

// File: tb/tb_ads_scan_ctrl.sv
// Directed bench for ads_scan_ctrl with a small I2C master responder model.
module tb_ads_scan_ctrl;

  localparam int CH_NUM = 4;
  localparam int CONV   = 20;
  localparam int GAP    = 10;
  localparam int AVG    = 2;
`ifdef ADS_AVG_EN
  localparam int NS = 1 << AVG;
`else
  localparam int NS = 1;
`endif

  logic              clk;
  logic              rst_n;
  logic              scan_en;
  logic [CH_NUM-1:0] ch_mask;
  logic              m_wr_req, m_rd_req;
  logic [1:0]        m_reg_addr;
  logic [15:0]       m_wdata;
  logic [15:0]       m_rdata;
  logic              m_done, m_ack_err;
  logic [15:0]       ad_voltage;
  logic [1:0]        ad_ch;
  logic              ad_voltage_valid, err, busy;

  ads_scan_ctrl #(
    .CH_NUM(CH_NUM), .PGA(3'b001), .DR(3'b100),
    .CONV_CYCLES(CONV), .GAP_CYCLES(GAP), .AVG_SHIFT(AVG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .ch_mask(ch_mask),
    .m_wr_req(m_wr_req), .m_rd_req(m_rd_req), .m_reg_addr(m_reg_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_done(m_done), .m_ack_err(m_ack_err),
    .ad_voltage(ad_voltage), .ad_ch(ad_ch), .ad_voltage_valid(ad_voltage_valid),
    .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // Observation logs
  logic [1:0]  emit_ch[$];
  logic [15:0] emit_v[$];
  int          emit_cyc[$];
  int          wr_rise[$];
  int          rd_rise[$];
  int          done_cyc[$];
  logic [15:0] wr_word[$];
  logic [1:0]  wr_addr[$];
  int          err_cnt = 0;
  int          both_bad = 0, stab_bad = 0, vld_bad = 0, err_bad = 0, rd_addr_bad = 0;

  // Master model controls
  logic [15:0] default_rd;
  logic [15:0] rd_vals[$];
  logic [1:0]  nack_ch;
  int          nack_left;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] rd;
    logic [15:0] cfg;
    logic [1:0]  ch;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // I2C master responder: m_done pulses on the 4th falling edge of a request.
  initial begin
    int lat;
    lat = 0;
    m_done = 1'b0; m_ack_err = 1'b0; m_rdata = 16'd0;
    forever begin
      @(negedge clk);
      m_done = 1'b0;
      m_ack_err = 1'b0;
      if (!rst_n) lat = 0;
      else if (m_wr_req || m_rd_req) begin
        lat++;
        if (lat == 4) begin
          lat = 0;
          m_done = 1'b1;
          if (m_wr_req) begin
            wr_word.push_back(m_wdata);
            wr_addr.push_back(m_reg_addr);
            done_cyc.push_back(cyc);
            if (nack_left > 0 && m_wdata[13:12] == nack_ch) begin
              m_ack_err = 1'b1;
              nack_left--;
            end
          end else begin
            if (m_reg_addr != 2'd0) rd_addr_bad++;
            m_rdata = (rd_vals.size() > 0) ? rd_vals.pop_front() : default_rd;
          end
        end
      end else lat = 0;
    end
  end

  // Protocol / output monitor
  initial begin
    logic wr_prev, rd_prev, vld_prev, err_prev;
    logic [15:0] wd_rise;
    wr_prev = 0; rd_prev = 0; vld_prev = 0; err_prev = 0; wd_rise = 0;
    forever begin
      @(negedge clk);
      if (m_wr_req && m_rd_req) both_bad++;
      if (m_wr_req && !wr_prev) begin
        wr_rise.push_back(cyc);
        wd_rise = m_wdata;
      end else if (m_wr_req && m_wdata !== wd_rise) stab_bad++;
      if (m_rd_req && !rd_prev) rd_rise.push_back(cyc);
      if (ad_voltage_valid) begin
        if (vld_prev) vld_bad++;
        emit_ch.push_back(ad_ch);
        emit_v.push_back(ad_voltage);
        emit_cyc.push_back(cyc);
      end
      if (err) begin
        if (err_prev) err_bad++;
        err_cnt++;
      end
      wr_prev = m_wr_req; rd_prev = m_rd_req; vld_prev = ad_voltage_valid; err_prev = err;
    end
  end

  function automatic int cnt_of(input int what);
    case (what)
      0:       return emit_v.size();
      1:       return done_cyc.size();
      2:       return wr_rise.size();
      default: return busy ? 0 : 1;
    endcase
  endfunction

  task automatic wait_for(input int what, input int n, input string nm);
    int b;
    b = 0;
    while (cnt_of(what) < n && b < 4000) begin
      @(negedge clk);
      b++;
    end
    if (cnt_of(what) < n) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: timeout, got %0d events, expected %0d", nm, cnt_of(what), n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    scan_en = 1'b0;
    rst_n = 1'b0;
    nack_left = 0;
    repeat (2) @(negedge clk);
    emit_ch.delete(); emit_v.delete(); emit_cyc.delete();
    wr_rise.delete(); rd_rise.delete(); done_cyc.delete();
    wr_word.delete(); wr_addr.delete(); rd_vals.delete();
    err_cnt = 0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{4'b0001, 16'h1234, 16'hC383, 2'd0};
    vt[1] = '{4'b0010, 16'hABCD, 16'hD383, 2'd1};
    vt[2] = '{4'b0100, 16'h8000, 16'hE383, 2'd2};
    vt[3] = '{4'b1000, 16'h7FFF, 16'hF383, 2'd3};

    rst_n = 1'b0; scan_en = 1'b0; ch_mask = '0;
    nack_left = 0; nack_ch = 2'd0; default_rd = 16'd0;

    // Reset state
    #1000;
    @(negedge clk);
    chk("rst_ctrl", {m_wr_req, m_rd_req, busy, ad_voltage_valid, err}, 0);
    chk("rst_bus", {m_reg_addr, m_wdata}, 0);
    chk("rst_result", {ad_ch, ad_voltage}, 0);
    rst_n = 1'b1;
    ch_mask = 4'b0001;
    repeat (30) @(negedge clk);
    chk("idle_no_req", wr_rise.size() + rd_rise.size(), 0);
    chk("idle_busy", busy, 0);

    // Table: one-hot masks, one conversion (or one averaged group) each
    for (int i = 0; i < 4; i++) begin
      do_reset();
      default_rd = vt[i].rd;
      ch_mask = vt[i].mask;
      scan_en = 1'b1;
      wait_for(0, 1, $sformatf("vec%0d_emit", i));
      scan_en = 1'b0;
      wait_for(3, 1, $sformatf("vec%0d_idle", i));
      if (wr_word.size() >= 1 && emit_v.size() >= 1) begin
        chk($sformatf("vec%0d_cfg", i), wr_word[0], vt[i].cfg);
        chk($sformatf("vec%0d_cfg_addr", i), wr_addr[0], 2'd1);
        chk($sformatf("vec%0d_ch", i), emit_ch[0], vt[i].ch);
        chk($sformatf("vec%0d_data", i), emit_v[0], vt[i].rd);
      end
      if (i == 0 && rd_rise.size() >= 1 && done_cyc.size() >= 1)
        chk("conv_wait", rd_rise[0] - done_cyc[0], CONV + 2);
    end

    // Mask 0101: skip and wrap, with an idle gap between rounds
    do_reset();
    default_rd = 16'h0555;
    ch_mask = 4'b0101;
    scan_en = 1'b1;
    wait_for(0, 4, "wrap_emits");
    scan_en = 1'b0;
    wait_for(3, 1, "wrap_idle");
    if (emit_ch.size() >= 4)
      chk("wrap_ch_seq", {emit_ch[0], emit_ch[1], emit_ch[2], emit_ch[3]},
          {2'd0, 2'd2, 2'd0, 2'd2});
    if (wr_word.size() > 2 * NS) begin
      chk("wrap_cfg_ch0", wr_word[0], 16'hC383);
      chk("wrap_cfg_ch2", wr_word[NS], 16'hE383);
      chk("wrap_cfg_ch0_r2", wr_word[2 * NS], 16'hC383);
      chk("gap_len", wr_rise[2 * NS] - emit_cyc[1], GAP + 2);
    end

    // NACK on the ch2 config write
    do_reset();
    default_rd = 16'h0321;
    nack_ch = 2'd2;
    nack_left = 1;
    ch_mask = 4'b0101;
    scan_en = 1'b1;
    wait_for(0, 3, "nack_emits");
    scan_en = 1'b0;
    wait_for(3, 1, "nack_idle");
    chk("nack_err_cnt", err_cnt, 1);
    if (emit_ch.size() >= 3)
      chk("nack_ch_seq", {emit_ch[0], emit_ch[1], emit_ch[2]}, {2'd0, 2'd0, 2'd2});

    // scan_en dropped while ch0 is converting
    do_reset();
    default_rd = 16'h0ABC;
    ch_mask = 4'b0101;
    scan_en = 1'b1;
    wait_for(1, 1, "drop_cfg");
    repeat (5) @(negedge clk);
    scan_en = 1'b0;
    wait_for(3, 1, "drop_idle");
    repeat (50) @(negedge clk);
    chk("drop_emit_cnt", emit_v.size(), 1);
    if (emit_v.size() >= 1) begin
      chk("drop_emit_ch", emit_ch[0], 2'd0);
      chk("drop_emit_data", emit_v[0], 16'h0ABC);
    end
    chk("drop_wr_cnt", wr_rise.size(), NS);
    chk("drop_busy", busy, 0);

    // Result data path: averaging or signed boundary codes
    do_reset();
    ch_mask = 4'b0001;
    default_rd = 16'h0000;
`ifdef ADS_AVG_EN
    rd_vals.push_back(16'h0010); rd_vals.push_back(16'h0020);
    rd_vals.push_back(16'h0030); rd_vals.push_back(16'h0040);
    for (int k = 0; k < 4; k++) rd_vals.push_back(16'hFFFC);
`else
    rd_vals.push_back(16'hFFFC);
    rd_vals.push_back(16'h0001);
`endif
    scan_en = 1'b1;
    wait_for(0, 2, "data_emits");
    scan_en = 1'b0;
    wait_for(3, 1, "data_idle");
    chk("data_emit_cnt", emit_v.size(), 2);
    if (emit_v.size() >= 2) begin
`ifdef ADS_AVG_EN
      chk("avg_pos", emit_v[0], 16'h0028);
      chk("avg_neg", emit_v[1], 16'hFFFC);
`else
      chk("data_neg", emit_v[0], 16'hFFFC);
      chk("data_one", emit_v[1], 16'h0001);
`endif
    end

    // Asynchronous reset during an outstanding write
    do_reset();
    default_rd = 16'h0000;
    ch_mask = 4'b0001;
    scan_en = 1'b1;
    wait_for(2, 1, "arst_req");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctrl", {m_wr_req, m_rd_req, busy}, 0);
    chk("arst_wdata", m_wdata, 0);
    scan_en = 1'b0;
    do_reset();

    // Protocol invariants accumulated over the whole run
    chk("req_exclusive", both_bad, 0);
    chk("wdata_stable", stab_bad, 0);
    chk("valid_1cyc", vld_bad, 0);
    chk("err_1cyc", err_bad, 0);
    chk("rd_reg_addr", rd_addr_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
